// File: rtl/signtrunc.sv
`default_nettype none
// ============================================================================
// Module      : signtrunc
// Description : Sign-truncation (narrowing) stage. Accepts an (N+NUM)-bit
//               two's-complement word over valid/ready and returns an N-bit
//               word through a 2-entry output buffer, flagging every sample
//               that does not fit in N bits. Keeps a sticky overflow flag and
//               a saturating 8-bit count of overflowing samples.
//               Build option SIGNTRUNC_SAT_EN: when defined, overflowing
//               samples saturate to the N-bit range; otherwise they wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module signtrunc #(
    parameter int N   = 8,
    parameter int NUM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N+NUM-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [7:0]       ovf_count,
    input  logic             clr
);

    localparam int c_W = N + NUM;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] head_q, head_d;
    logic         head_ovf_q, head_ovf_d;
    logic [N-1:0] tail_q, tail_d;
    logic         tail_ovf_q, tail_ovf_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         sticky_q, sticky_d;
    logic [7:0]   count_q, count_d;

    logic [NUM:0] w_top;
    logic         w_ovf;
    logic [N-1:0] w_result;
    logic         w_push;
    logic         w_pop;

    // The sample fits when every bit from the N-bit sign position upward agrees.
    assign w_top = in[c_W-1:N-1];
    assign w_ovf = ~((&w_top) | ~(|w_top));

`ifdef SIGNTRUNC_SAT_EN
    // Overflow clamps to the most positive or most negative N-bit value.
    assign w_result = !w_ovf      ? in[N-1:0] :
                      in[c_W-1]   ? {1'b1, {(N-1){1'b0}}} :
                                    {1'b0, {(N-1){1'b1}}};
`else
    // Overflow keeps the low bits (wrap-around); only the flag reports it.
    assign w_result = in[N-1:0];
`endif

    // Handshakes use registered ready/valid only, so no input-to-output paths.
    assign w_push = in_valid & in_ready_q;
    assign w_pop  = out_valid_q & out_ready;

    // Next-state, buffer and statistics logic.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        head_ovf_d = head_ovf_q;
        tail_d     = tail_q;
        tail_ovf_d = tail_ovf_q;
        sticky_d   = sticky_q;
        count_d    = count_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_push) begin
                    head_d     = w_result;
                    head_ovf_d = w_ovf;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    // Old head leaves as the new word arrives: it becomes head.
                    head_d     = w_result;
                    head_ovf_d = w_ovf;
                end else if (w_push) begin
                    tail_d     = w_result;
                    tail_ovf_d = w_ovf;
                    state_d    = ST_FULL;
                end else if (w_pop) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    head_d     = tail_q;
                    head_ovf_d = tail_ovf_q;
                    state_d    = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Outputs are registered copies of the next state's properties.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);

        // Clear has priority over a simultaneous overflowing push.
        if (clr) begin
            sticky_d = 1'b0;
            count_d  = 8'd0;
        end else if (w_push && w_ovf) begin
            sticky_d = 1'b1;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end
    end

    // State and output registers; in_ready stays low until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            head_ovf_q  <= 1'b0;
            tail_q      <= '0;
            tail_ovf_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            head_ovf_q  <= head_ovf_d;
            tail_q      <= tail_d;
            tail_ovf_q  <= tail_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out        = head_q;
    assign ovf        = head_ovf_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_signtrunc.sv
`default_nettype none
// ============================================================================
// Module      : tb_signtrunc
// Description : Self-checking bench for signtrunc (N=8, NUM=4). A queue-based
//               reference model tracks buffer contents and statistics using
//               plain integer arithmetic; directed scenarios plus random
//               traffic are compared against it every cycle. Honors the
//               SIGNTRUNC_SAT_EN build option in its expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signtrunc;

    localparam int c_N   = 8;
    localparam int c_NUM = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [c_N+c_NUM-1:0]   in = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [c_N-1:0]         out;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   ovf;
    logic                   ovf_sticky;
    logic [7:0]             ovf_count;
    logic                   clr = 1'b0;

    signtrunc #(.N(c_N), .NUM(c_NUM)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    logic [8:0] m_q[$];      // {ovf, out[7:0]} entries, head first
    int         m_count = 0;
    bit         m_sticky = 0;
    bit         m_rdy_ok = 0; // in_ready only rises one edge after reset ends

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected narrowed value from the numeric range of the input.
    task automatic model_narrow(input logic [11:0] x, output logic [7:0] o, output logic v);
        int val;
        logic [7:0] lo;
        val = int'($signed(x));
        lo  = x[7:0];
        v   = (val > 127) || (val < -128);
`ifdef SIGNTRUNC_SAT_EN
        if (!v)            o = lo;
        else if (val > 0)  o = 8'h7F;
        else               o = 8'h80;
`else
        o = lo;
`endif
    endtask

    // Compare every observable output with the model.
    task automatic check_all();
        logic [8:0] h;
        check("out_valid",  {31'd0, out_valid}, {31'd0, m_q.size() > 0});
        check("in_ready",   {31'd0, in_ready},  {31'd0, m_rdy_ok && m_q.size() < 2});
        check("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
        check("ovf_count",  {24'd0, ovf_count}, m_count);
        if (m_q.size() > 0) begin
            h = m_q[0];
            check("out", {24'd0, out}, {24'd0, h[7:0]});
            check("ovf", {31'd0, ovf}, {31'd0, h[8]});
        end
    endtask

    // Apply one cycle of inputs, advance the model over the edge, then check.
    task automatic step(input logic v, input logic [11:0] d, input logic ordy, input logic c);
        bit push, pop;
        logic [7:0] o;
        logic f;
        in_valid  = v;
        in        = d;
        out_ready = ordy;
        clr       = c;
        push = v && m_rdy_ok && (m_q.size() < 2);
        pop  = ordy && (m_q.size() > 0);
        model_narrow(d, o, f);
        @(posedge clk);
        #1;
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back({f, o});
        if (c) begin
            m_count  = 0;
            m_sticky = 0;
        end else if (push && f) begin
            m_sticky = 1;
            if (m_count < 255) m_count++;
        end
        m_rdy_ok = 1;
        check_all();
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        logic [11:0] r;
        // Reset state, applied asynchronously.
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out",       {24'd0, out},       32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_count",     {24'd0, ovf_count}, 32'd0);
        check("rst_sticky",    {31'd0, ovf_sticky}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        m_rdy_ok = 0;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd0);

        // First edge after reset only raises in_ready; the offered word is refused.
        step(1'b1, 12'h07F, 1'b1, 1'b0);
        check("rdy_rise", {31'd0, in_ready}, 32'd1);

        // Fit cases.
        step(1'b1, 12'h07F, 1'b1, 1'b0);
        check("fit_pos", {23'd0, ovf, out}, {23'd0, 1'b0, 8'h7F});
        step(1'b1, 12'hF80, 1'b1, 1'b0);
        check("fit_neg", {23'd0, ovf, out}, {23'd0, 1'b0, 8'h80});

        // Overflow cases.
        step(1'b1, 12'h080, 1'b1, 1'b0);
`ifdef SIGNTRUNC_SAT_EN
        check("ovf_pos_sat", {23'd0, ovf, out}, {23'd0, 1'b1, 8'h7F});
        step(1'b1, 12'hF7F, 1'b1, 1'b0);
        check("ovf_neg_sat", {23'd0, ovf, out}, {23'd0, 1'b1, 8'h80});
`else
        check("ovf_pos_wrap", {23'd0, ovf, out}, {23'd0, 1'b1, 8'h80});
        step(1'b1, 12'h123, 1'b1, 1'b0);
        check("ovf_wrap_123", {23'd0, ovf, out}, {23'd0, 1'b1, 8'h23});
`endif
        check("stats_cnt2", {24'd0, ovf_count}, 32'd2);
        check("stats_sticky", {31'd0, ovf_sticky}, 32'd1);
        step(1'b0, 12'h000, 1'b1, 1'b0);

        // Backpressure: third word held until the consumer drains.
        step(1'b1, 12'h001, 1'b0, 1'b0);
        step(1'b1, 12'h002, 1'b0, 1'b0);
        check("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        step(1'b1, 12'h003, 1'b0, 1'b0);
        check("bp_hold_out", {24'd0, out}, 32'h01);
        step(1'b1, 12'h003, 1'b1, 1'b0);
        check("bp_out2", {24'd0, out}, 32'h02);
        step(1'b1, 12'h003, 1'b1, 1'b0);
        check("bp_out3", {24'd0, out}, 32'h03);
        step(1'b0, 12'h000, 1'b1, 1'b0);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Saturating counter.
        step(1'b0, 12'h000, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 12'h800, 1'b1, 1'b0);
        check("cnt_sat", {24'd0, ovf_count}, 32'd255);
        step(1'b1, 12'h800, 1'b1, 1'b0);
        check("cnt_hold", {24'd0, ovf_count}, 32'd255);
        // Clear wins over an overflowing push.
        step(1'b1, 12'h800, 1'b1, 1'b1);
        check("clr_cnt", {24'd0, ovf_count}, 32'd0);
        check("clr_sticky", {31'd0, ovf_sticky}, 32'd0);

        // Random traffic biased toward the fit boundary.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: r = 12'($urandom_range(0, 4095));
                1: r = 12'($urandom_range(120, 136));
                2: r = 12'(12'hF78 + 12'($urandom_range(0, 16)));
                default: r = {{4{1'($urandom_range(0, 1))}}, 8'($urandom_range(0, 255))};
            endcase
            step(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
        end

        // Reset mid-operation from FULL.
        step(1'b0, 12'h000, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b0);
        step(1'b1, 12'h800, 1'b0, 1'b0);
        step(1'b1, 12'h801, 1'b0, 1'b0);
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {24'd0, ovf_count}, 32'd0);
        #1 rst = 1'b0;
        m_q.delete();
        m_count  = 0;
        m_sticky = 0;
        m_rdy_ok = 0;
        step(1'b0, 12'h000, 1'b1, 1'b0);
        step(1'b1, 12'h005, 1'b1, 1'b0);
        check("post_rst_push", {23'd0, out_valid, out}, {23'd0, 1'b1, 8'h05});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
